// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter
//   Board memory for the battleship game. It holds one DEPTH x ROW_W row array
//   per player. Three requesters share the write path: the ship-placement
//   validator, the shot collider and a bulk board-clear sequencer. The VGA
//   renderer has its own read port, which is never stalled.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   vga_player/vga_addr        display row select
//   vga_rdata                  registered row (0 when the select is out of range)
//   val_req/player/addr/wdata  placement request
//   val_gnt/val_done           grant, completion pulse
//   val_conflito               overlap flag, valid with val_done
//   col_req/player/addr/mask   shot request
//   col_gnt/col_done           grant, completion pulse
//   col_hit                    hit flag, valid with col_done
//   err_borda                  out-of-range flag, valid with val_done/col_done
//   clr_req/clr_player         clear-board request
//   clr_busy/clr_done          clear in progress, completion pulse
module board_mem_arbiter #(
  parameter int ROW_W   = 64,
  parameter int DEPTH   = 12,
  parameter int ADDR_W  = 5,
  parameter int PLAYERS = 2,
  parameter int PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PW-1:0]     vga_player,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [ROW_W-1:0]  vga_rdata,
  input  logic              val_req,
  input  logic [PW-1:0]     val_player,
  input  logic [ADDR_W-1:0] val_addr,
  input  logic [ROW_W-1:0]  val_wdata,
  output logic              val_gnt,
  output logic              val_done,
  output logic              val_conflito,
  input  logic              col_req,
  input  logic [PW-1:0]     col_player,
  input  logic [ADDR_W-1:0] col_addr,
  input  logic [ROW_W-1:0]  col_mask,
  output logic              col_gnt,
  output logic              col_done,
  output logic              col_hit,
  output logic              err_borda,
  input  logic              clr_req,
  input  logic [PW-1:0]     clr_player,
  output logic              clr_busy,
  output logic              clr_done
);

  localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, CLEAR = 2'd2} state_t;

  state_t state_q, state_d;

  logic [ROW_W-1:0]  mem [PLAYERS][DEPTH];

  // Operation latched at grant time
  logic              op_col;
  logic [PW-1:0]     op_player;
  logic [ADDR_W-1:0] op_addr;
  logic [ROW_W-1:0]  op_data;

  logic              rr_col;        // 1: col wins the next val/col tie
  logic [PW-1:0]     clr_player_q;
  logic [DW-1:0]     clr_cnt;

  logic              op_ok, vga_ok, clr_ok, clr_last, overlap, grant;
  logic [ROW_W-1:0]  cur_row;

  assign grant = val_gnt | col_gnt;

  always_comb begin
    op_ok    = (int'(op_player) < PLAYERS) && (int'(op_addr) < DEPTH);
    vga_ok   = (int'(vga_player) < PLAYERS) && (int'(vga_addr) < DEPTH);
    clr_ok   = (int'(clr_player_q) < PLAYERS);
    clr_last = (clr_cnt == DW'(DEPTH - 1));
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    cur_row  = '0;
    if (op_ok) cur_row = mem[op_player][op_addr[DW-1:0]];
    overlap  = |(cur_row & op_data);
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a clear request outranks val/col in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
               else if (grant) state_d = EXEC;
      EXEC:    state_d = IDLE;
      CLEAR:   if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: grants only in IDLE, round-robin on a val/col tie
  always_comb begin
    val_gnt  = 1'b0;
    col_gnt  = 1'b0;
    clr_busy = (state_q == CLEAR);
    if (state_q == IDLE && !clr_req) begin
      if (val_req && (!col_req || !rr_col)) val_gnt = 1'b1;
      else if (col_req)                      col_gnt = 1'b1;
    end
  end

  // Board storage. Reset has priority, so a reset during EXEC/CLEAR drops the
  // pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: boards must read as empty straight after reset, so the array is
      // built from resettable flops instead of an uninitialised RAM.
      for (int p = 0; p < PLAYERS; p++)
        for (int r = 0; r < DEPTH; r++)
          mem[p][r] <= '0;
    end else if (state_q == EXEC && op_ok) begin
      if (op_col)        mem[op_player][op_addr[DW-1:0]] <= cur_row & ~op_data;
      else if (!overlap) mem[op_player][op_addr[DW-1:0]] <= cur_row | op_data;
    end else if (state_q == CLEAR && clr_ok) begin
      mem[clr_player_q][clr_cnt] <= '0;
    end
  end

  // VGA read port: a same-cycle write is seen one cycle later (old row now)
  always_ff @(posedge clk) begin
    if (reset)       vga_rdata <= '0;
    else if (vga_ok) vga_rdata <= mem[vga_player][vga_addr[DW-1:0]];
    else             vga_rdata <= '0;
  end

  // Operation latch, clear counter, done pulses and held result flags
  always_ff @(posedge clk) begin
    if (reset) begin
      op_col       <= 1'b0;
      op_player    <= '0;
      op_addr      <= '0;
      op_data      <= '0;
      rr_col       <= 1'b0;
      clr_player_q <= '0;
      clr_cnt      <= '0;
      val_done     <= 1'b0;
      col_done     <= 1'b0;
      clr_done     <= 1'b0;
      val_conflito <= 1'b0;
      col_hit      <= 1'b0;
      err_borda    <= 1'b0;
    end else begin
      val_done <= 1'b0;
      col_done <= 1'b0;
      clr_done <= 1'b0;

      if (grant) begin
        op_col    <= col_gnt;
        op_player <= col_gnt ? col_player : val_player;
        op_addr   <= col_gnt ? col_addr   : val_addr;
        op_data   <= col_gnt ? col_mask   : val_wdata;
        rr_col    <= ~rr_col;
      end

      if (state_q == IDLE && clr_req) begin
        clr_player_q <= clr_player;
        clr_cnt      <= '0;
      end else if (state_q == CLEAR) begin
        clr_cnt <= clr_cnt + DW'(1);
        if (clr_last) clr_done <= 1'b1;
      end

      if (state_q == EXEC) begin
        err_borda <= ~op_ok;
        if (op_col) begin
          col_done <= 1'b1;
          col_hit  <= op_ok & overlap;
        end else begin
          val_done     <= 1'b1;
          val_conflito <= op_ok & overlap;
        end
      end
    end
  end

endmodule
